// File: rtl/spw_rx_fifo_ctrl.sv
// SpaceWire receive FIFO controller: pulls 9-bit codec characters into a FIFO
// and exposes them to the CPU as Avalon-MM DATA/STATUS/CONTROL/IRQSTAT registers.
module spw_rx_fifo_ctrl #(
   parameter int DEPTH     = 16,
   parameter int AW        = 4,
   parameter int WATERMARK = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        irq,
   input  logic        rx_valid,
   input  logic [8:0]  rx_data,
   output logic        rx_read,
   output logic        fsm_state
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_GAP  = 1'b1
   } state_t;

   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   WM_LVL   = (AW+1)'(WATERMARK);
   localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_STATUS  = 2'd1;
   localparam logic [1:0] ADDR_CONTROL = 2'd2;
   localparam logic [1:0] ADDR_IRQSTAT = 2'd3;

   state_t        state;
   state_t        state_next;

   logic [8:0]    mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [AW:0]   count;
   logic [AW:0]   count_next;
   logic [AW:0]   pkt_cnt;
   logic [AW:0]   pkt_next;

   logic          ctrl_en;
   logic          ctrl_wm_en;
   logic          ctrl_eop_en;
   logic          wm_q;
   logic          eop_q;

   logic          empty;
   logic          full;
   logic          flush;
   logic          ctrl_wr;
   logic          stat_wr;
   logic          push;
   logic          pop;
   logic          push_flag;
   logic          pop_flag;
   logic          wm_set;
   logic          eop_set;
   logic [8:0]    head;
   logic [8:0]    pkt_ext;
   logic [7:0]    pkt_sat;
   logic [31:0]   status_word;
   logic [31:0]   control_word;
   logic [31:0]   irqstat_word;
   logic [31:0]   data_word;
   logic          unused_wdata;

   assign unused_wdata = ^writedata[31:4];

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign ctrl_wr = write && (address == ADDR_CONTROL);
   assign stat_wr = write && (address == ADDR_IRQSTAT);
   // Flush overrides both a same-cycle push and a same-cycle pop.
   assign flush   = ctrl_wr && writedata[3];
   assign pop     = read && (address == ADDR_DATA) && !empty && !flush;
   assign head    = mem[rptr];

   assign push_flag = push && rx_data[8];
   assign pop_flag  = pop && head[8];

   // ---------------- ingress FSM ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE: if (push) state_next = ST_GAP;
         ST_GAP:  state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
      if (flush) state_next = ST_IDLE;
   end

   always_comb begin
      push      = (state == ST_IDLE) && ctrl_en && rx_valid && !full && !flush;
      rx_read   = push;
      fsm_state = (state == ST_GAP);
   end

   // ---------------- FIFO storage and occupancy ----------------
   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= rx_data;
   end

   always_comb begin
      count_next = count;
      if (flush)             count_next = '0;
      else if (push && !pop) count_next = count + CNT_ONE;
      else if (pop && !push) count_next = count - CNT_ONE;
   end

   always_comb begin
      pkt_next = pkt_cnt;
      if (flush)                      pkt_next = '0;
      else if (push_flag && !pop_flag) pkt_next = pkt_cnt + CNT_ONE;
      else if (pop_flag && !push_flag) pkt_next = pkt_cnt - CNT_ONE;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr    <= '0;
         rptr    <= '0;
         count   <= '0;
         pkt_cnt <= '0;
      end else begin
         count   <= count_next;
         pkt_cnt <= pkt_next;
         if (flush) begin
            wptr <= '0;
            rptr <= '0;
         end else begin
            if (push) wptr <= wptr + PTR_ONE;
            if (pop)  rptr <= rptr + PTR_ONE;
         end
      end
   end

   // ---------------- control and interrupt status ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl_en     <= 1'b0;
         ctrl_wm_en  <= 1'b0;
         ctrl_eop_en <= 1'b0;
      end else if (ctrl_wr) begin
         ctrl_en     <= writedata[0];
         ctrl_wm_en  <= writedata[1];
         ctrl_eop_en <= writedata[2];
      end
   end

   // Watermark fires only on the upward crossing, not while merely above it.
   assign wm_set  = (count < WM_LVL) && (count_next >= WM_LVL);
   assign eop_set = push_flag;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wm_q  <= 1'b0;
         eop_q <= 1'b0;
         irq   <= 1'b0;
      end else begin
         wm_q  <= wm_set  | (wm_q  & ~(stat_wr & writedata[0]));
         eop_q <= eop_set | (eop_q & ~(stat_wr & writedata[1]));
         irq   <= (wm_q & ctrl_wm_en) | (eop_q & ctrl_eop_en);
      end
   end

   // ---------------- register read path ----------------
   assign pkt_ext = 9'(pkt_cnt);
   assign pkt_sat = pkt_ext[8] ? 8'hFF : pkt_ext[7:0];

   always_comb begin
      status_word  = 32'(count)
                   | {22'b0, full, empty, 8'b0}
                   | {8'b0, pkt_sat, 16'b0};
      control_word = {29'b0, ctrl_eop_en, ctrl_wm_en, ctrl_en};
      irqstat_word = {30'b0, eop_q, wm_q};
      data_word    = pop ? {1'b1, 22'b0, head} : 32'b0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata <= '0;
      end else if (read) begin
         unique case (address)
            ADDR_DATA:    readdata <= data_word;
            ADDR_STATUS:  readdata <= status_word;
            ADDR_CONTROL: readdata <= control_word;
            ADDR_IRQSTAT: readdata <= irqstat_word;
            default:      readdata <= '0;
         endcase
      end
   end

endmodule
